// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
// Provides the FSM state type, the index-width rule and the reqData slice offset.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arbState_t;

   // Index width for an n-entry requester set; never zero even for degenerate n.
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Bit offset of requester idx inside a flattened data bus.
   function automatic int sliceLsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after start, with wrap.
// start is assumed to be in range 0..N_REQ-1.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]               req,
   input  logic [idxWidth(N_REQ)-1:0]     start,
   output logic                           found,
   output logic [idxWidth(N_REQ)-1:0]     idx
);

   localparam int IDX_W = idxWidth(N_REQ);

   // Scan from the farthest candidate back to start so the nearest hit is written last.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path can infer a latch.
      found = 1'b0;
      idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         int j;
         j = int'(start) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (req[j]) begin
            found = 1'b1;
            idx   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one fifo write port among N_REQ valid/ready requesters.
// Bursts are capped at MAX_BURST beats; a stalled beat always holds its grant.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int FIFO_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              reqValid,
   output logic [N_REQ-1:0]              reqReady,
   input  logic [N_REQ*FIFO_WIDTH-1:0]   reqData,
   output logic                          writeValid,
   input  logic                          writeReady,
   output logic [FIFO_WIDTH-1:0]         writeData,
   output logic [idxWidth(N_REQ)-1:0]    grantId,
   output logic                          busy
);

   localparam int IDX_W = idxWidth(N_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

   arbState_t         state, stateNext;
   logic [IDX_W-1:0]  rrPtr, rrPtrNext;
   logic [IDX_W-1:0]  grantNext, succIdx, pickStart, pickIdx;
   logic [CNT_W-1:0]  beatCnt, beatCntNext;
   logic              pickFound, beat, rotate;
   logic [FIFO_WIDTH-1:0] reqWord [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign reqWord[i] = reqData[sliceLsb(i, FIFO_WIDTH) +: FIFO_WIDTH];
   end

   // Successor of the current grant; explicit wrap keeps non-power-of-two N_REQ in range.
   assign succIdx   = (grantId == LAST_IDX) ? '0 : grantId + 1'b1;
   assign pickStart = (state == GRANT) ? succIdx : rrPtr;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req   (reqValid),
      .start (pickStart),
      .found (pickFound),
      .idx   (pickIdx)
   );

   // Datapath and handshake outputs are combinational from the registered grant.
   always_comb begin
      busy       = 1'b0;
      writeValid = 1'b0;
      writeData  = '0;
      reqReady   = '0;
      beat       = 1'b0;
      rotate     = 1'b0;
      if (state == GRANT) begin
         busy              = 1'b1;
         writeValid        = reqValid[grantId];
         writeData         = reqWord[grantId];
         reqReady[grantId] = writeReady;
         beat              = reqValid[grantId] && writeReady;
         rotate            = !reqValid[grantId] || (beat && (beatCnt == LAST_BEAT));
      end
   end

   // A pending beat (valid without ready) never rotates, so grant and data stay put.
   always_comb begin
      stateNext   = state;
      grantNext   = grantId;
      rrPtrNext   = rrPtr;
      beatCntNext = beatCnt;
      unique case (state)
         IDLE: begin
            if (pickFound) begin
               stateNext   = GRANT;
               grantNext   = pickIdx;
               beatCntNext = '0;
            end
         end
         GRANT: begin
            if (rotate) begin
               rrPtrNext   = succIdx;
               beatCntNext = '0;
               if (pickFound) grantNext = pickIdx;
               else           stateNext = IDLE;
            end else if (beat) begin
               beatCntNext = beatCnt + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         grantId <= '0;
         rrPtr   <= '0;
         beatCnt <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state   <= stateNext;
         grantId <= grantNext;
         rrPtr   <= rrPtrNext;
         beatCnt <= beatCntNext;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: vector table, directed corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_fifo_write_arbiter;

   localparam int N  = 4;
   localparam int MB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  reqValid, reqReady;
   logic [31:0] reqData;
   logic        writeValid, writeReady;
   logic [7:0]  writeData;
   logic [1:0]  grantId;
   logic        busy;

   logic [2:0]  reqValid3, reqReady3;
   logic [23:0] reqData3;
   logic        writeValid3, writeReady3;
   logic [7:0]  writeData3;
   logic [1:0]  grantId3;
   logic        busy3;

   int total = 0;
   int bad   = 0;

   fifo_write_arbiter #(.N_REQ(4), .FIFO_WIDTH(8), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady), .reqData(reqData),
      .writeValid(writeValid), .writeReady(writeReady), .writeData(writeData),
      .grantId(grantId), .busy(busy)
   );

   fifo_write_arbiter #(.N_REQ(3), .FIFO_WIDTH(8), .MAX_BURST(2)) dut3 (
      .clk(clk), .rst(rst), .reqValid(reqValid3), .reqReady(reqReady3), .reqData(reqData3),
      .writeValid(writeValid3), .writeReady(writeReady3), .writeData(writeData3),
      .grantId(grantId3), .busy(busy3)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   typedef struct {
      logic [3:0] v;
      logic       wr;
      logic       eBusy;
      int         eG;
      logic       eWv;
      logic [3:0] eRr;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Packed compare of {busy, grantId, writeValid, writeData, reqReady}; grantId masked when idle.
   task automatic expectOut(input string name, input int eBusy, input int eG, input int eWv,
                            input int eWd, input int eRr);
      logic [15:0] act, exp;
      act = {busy, (eBusy != 0) ? grantId : 2'b00, writeValid, writeData, reqReady};
      exp = {1'(eBusy), (eBusy != 0) ? 2'(eG) : 2'b00, 1'(eWv), 8'(eWd), 4'(eRr)};
      check(name, 32'(act), 32'(exp));
   endtask

   task automatic expect3(input string name, input int eBusy, input int eG, input int eWv,
                          input int eWd);
      logic [14:0] act, exp;
      act = {busy3, (eBusy != 0) ? grantId3 : 2'b00, writeValid3, writeData3, 3'b000};
      exp = {1'(eBusy), (eBusy != 0) ? 2'(eG) : 2'b00, 1'(eWv), 8'(eWd), 3'b000};
      check(name, 32'(act), 32'(exp));
      check({name, "_range"}, 32'(grantId3 < 2'd3), 32'd1);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic doReset();
      rst         = 1'b0;
      reqValid    = '0;
      reqData     = '0;
      writeReady  = 1'b0;
      reqValid3   = '0;
      reqData3    = '0;
      writeReady3 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   function automatic int pickFrom(input logic [3:0] v, input int start);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (start + k) % N;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   initial begin
      int mG, mPtr, mCnt, p;
      bit mBusy, bt;
      logic [3:0] v, acc;
      logic wr;

      // Vector table: inputs for one cycle, expected combinational outputs in that cycle.
      vecs[0]  = '{4'b0000, 1'b1, 1'b0, 0, 1'b0, 4'b0000};
      vecs[1]  = '{4'b0100, 1'b1, 1'b0, 0, 1'b0, 4'b0000};
      vecs[2]  = '{4'b0100, 1'b1, 1'b1, 2, 1'b1, 4'b0100};
      vecs[3]  = '{4'b0110, 1'b0, 1'b1, 2, 1'b1, 4'b0000};
      vecs[4]  = '{4'b0110, 1'b1, 1'b1, 2, 1'b1, 4'b0100};
      vecs[5]  = '{4'b0010, 1'b1, 1'b1, 2, 1'b0, 4'b0100};
      vecs[6]  = '{4'b0010, 1'b1, 1'b1, 1, 1'b1, 4'b0010};
      vecs[7]  = '{4'b0010, 1'b1, 1'b1, 1, 1'b1, 4'b0010};
      vecs[8]  = '{4'b0010, 1'b1, 1'b1, 1, 1'b1, 4'b0010};
      vecs[9]  = '{4'b0010, 1'b1, 1'b1, 1, 1'b1, 4'b0010};
      vecs[10] = '{4'b1010, 1'b1, 1'b1, 1, 1'b1, 4'b0010};
      vecs[11] = '{4'b1000, 1'b1, 1'b1, 1, 1'b0, 4'b0010};
      vecs[12] = '{4'b1000, 1'b1, 1'b1, 3, 1'b1, 4'b1000};
      vecs[13] = '{4'b0000, 1'b1, 1'b1, 3, 1'b0, 4'b1000};
      vecs[14] = '{4'b0000, 1'b1, 1'b0, 0, 1'b0, 4'b0000};

      // Reset state, observed while reset is held with requesters active.
      rst = 1'b0;
      reqValid = 4'b1111; reqData = 32'hDEADBEEF; writeReady = 1'b1;
      reqValid3 = 3'b111; reqData3 = 24'h123456; writeReady3 = 1'b1;
      #12;
      expectOut("reset_state", 0, 0, 0, 0, 0);
      check("reset_gid", 32'(grantId), 32'd0);
      expect3("reset_state3", 0, 0, 0, 0);

      // Table-driven vectors.
      doReset();
      reqData = 32'hC3C2C1C0;
      for (int r = 0; r < 15; r++) begin
         reqValid   = vecs[r].v;
         writeReady = vecs[r].wr;
         sample();
         expectOut($sformatf("vec%0d", r), int'(vecs[r].eBusy), vecs[r].eG, int'(vecs[r].eWv),
                   vecs[r].eBusy ? 8'hC0 + 8'(vecs[r].eG) : 8'h00, int'(vecs[r].eRr));
         nextCycle();
      end

      // Single requester: six beats stream with regrant after four, one-cycle grant latency.
      doReset();
      reqValid = 4'b0100; writeReady = 1'b1; reqData[23:16] = 8'hA0;
      sample();
      expectOut("single_latency", 0, 0, 0, 0, 0);
      nextCycle();
      for (int k = 0; k < 6; k++) begin
         reqData[23:16] = 8'hA0 + 8'(k);
         sample();
         expectOut($sformatf("single_beat%0d", k), 1, 2, 1, 8'hA0 + 8'(k), 4'b0100);
         nextCycle();
      end
      reqValid = 4'b0000;
      sample();
      expectOut("single_release", 1, 2, 0, 8'hA5, 4'b0100);
      nextCycle();
      sample();
      expectOut("single_idle", 0, 0, 0, 0, 0);

      // Fairness: all valid, four beats each in order 0,1,2,3,0 with no bubble.
      doReset();
      reqValid = 4'b1111; writeReady = 1'b1; reqData = 32'h33221100;
      sample();
      expectOut("fair_idle", 0, 0, 0, 0, 0);
      nextCycle();
      for (int k = 0; k < 17; k++) begin
         int g;
         g = (k / MB) % N;
         sample();
         expectOut($sformatf("fair%0d", k), 1, g, 1, g * 8'h11, 4'b0001 << g);
         nextCycle();
      end

      // Backpressure: grant and data stable for five stalled cycles, then rotate to 3.
      doReset();
      reqValid = 4'b1010; writeReady = 1'b0; reqData = 32'h63006100;
      sample();
      expectOut("bp_idle", 0, 0, 0, 0, 0);
      nextCycle();
      for (int k = 0; k < 5; k++) begin
         sample();
         expectOut($sformatf("bp_stall%0d", k), 1, 1, 1, 8'h61, 4'b0000);
         nextCycle();
      end
      writeReady = 1'b1;
      sample();
      expectOut("bp_release", 1, 1, 1, 8'h61, 4'b0010);
      nextCycle();
      reqValid = 4'b1000;
      sample();
      expectOut("bp_drop", 1, 1, 0, 8'h61, 4'b0010);
      nextCycle();
      sample();
      expectOut("bp_next", 1, 3, 1, 8'h63, 4'b1000);

      // Early release: requester 0 quits after two beats; 1 takes a full fresh burst.
      doReset();
      reqValid = 4'b0011; writeReady = 1'b1; reqData = 32'h00007170;
      sample();
      nextCycle();
      for (int k = 0; k < 2; k++) begin
         sample();
         expectOut($sformatf("early_beat%0d", k), 1, 0, 1, 8'h70, 4'b0001);
         nextCycle();
      end
      reqValid = 4'b0010;
      sample();
      expectOut("early_drop", 1, 0, 0, 8'h70, 4'b0001);
      nextCycle();
      reqValid = 4'b0011;
      for (int k = 0; k < MB; k++) begin
         sample();
         expectOut($sformatf("early_r1_%0d", k), 1, 1, 1, 8'h71, 4'b0010);
         nextCycle();
      end
      sample();
      expectOut("early_back0", 1, 0, 1, 8'h70, 4'b0001);

      // Reset during a stalled third beat of requester 2; first grant afterwards is 1.
      doReset();
      reqValid = 4'b0100; writeReady = 1'b1; reqData = 32'h53B05100;
      sample();
      nextCycle();
      for (int k = 0; k < 2; k++) begin
         reqData[23:16] = 8'hB0 + 8'(k);
         sample();
         expectOut($sformatf("rst_beat%0d", k), 1, 2, 1, 8'hB0 + 8'(k), 4'b0100);
         nextCycle();
      end
      reqData[23:16] = 8'hB2; writeReady = 1'b0;
      sample();
      expectOut("rst_pending", 1, 2, 1, 8'hB2, 4'b0000);
      #2;
      rst = 1'b0;
      #1;
      expectOut("rst_abort", 0, 0, 0, 0, 0);
      check("rst_abort_gid", 32'(grantId), 32'd0);
      @(posedge clk);
      #1;
      reqValid = 4'b1010; writeReady = 1'b1; rst = 1'b1;
      sample();
      expectOut("rst_after_idle", 0, 0, 0, 0, 0);
      nextCycle();
      sample();
      expectOut("rst_first_grant", 1, 1, 1, 8'h51, 4'b0010);

      // Wrap with N_REQ=3, MAX_BURST=2: rrPtr lands on 2, then grants 2 and 0.
      doReset();
      reqData3 = 24'hE2E1E0; writeReady3 = 1'b1; reqValid3 = 3'b010;
      sample();
      expect3("wrap_idle", 0, 0, 0, 0);
      nextCycle();
      sample();
      expect3("wrap_g1", 1, 1, 1, 8'hE1);
      nextCycle();
      reqValid3 = 3'b101;
      sample();
      expect3("wrap_drop1", 1, 1, 0, 8'hE1);
      nextCycle();
      for (int k = 0; k < 2; k++) begin
         sample();
         expect3($sformatf("wrap_g2_%0d", k), 1, 2, 1, 8'hE2);
         nextCycle();
      end
      sample();
      expect3("wrap_g0", 1, 0, 1, 8'hE0);
      nextCycle();

      // Randomized traffic against the reference model; requesters obey valid/ready holding.
      doReset();
      mBusy = 1'b0; mG = 0; mPtr = 0; mCnt = 0; acc = '0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!reqValid[i] || acc[i]) begin
               reqValid[i]     = ($urandom_range(3) != 0);
               reqData[i*8 +: 8] = 8'($urandom);
            end
         end
         writeReady = ($urandom_range(3) != 0);
         sample();
         v  = reqValid;
         wr = writeReady;
         if (mBusy)
            expectOut($sformatf("rand%0d", c), 1, mG, int'(v[mG]), int'(reqData[mG*8 +: 8]),
                      wr ? (1 << mG) : 0);
         else
            expectOut($sformatf("rand%0d", c), 0, 0, 0, 0, 0);
         if (!mBusy) begin
            p = pickFrom(v, mPtr);
            if (p >= 0) begin
               mBusy = 1'b1; mG = p; mCnt = 0;
            end
         end else begin
            bt = v[mG] && wr;
            if (bt) mCnt++;
            if (!v[mG] || (bt && mCnt == MB)) begin
               mPtr = (mG + 1) % N;
               p = pickFrom(v, mPtr);
               if (p >= 0) begin
                  mG = p; mCnt = 0;
               end else begin
                  mBusy = 1'b0;
               end
            end
         end
         acc = reqValid & reqReady;
         nextCycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
